// File: rtl/aes128_round_ctrl.sv
// AES-128 encryption sequencer: owns the state register and round counter,
// pulls one round key per round from the key-expansion block, and applies one cipher round per accepted key.
module aes128_round_ctrl #(
    parameter int NR          = 10,  // AES-128 only
    parameter int KEY_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] plaintext,
    output logic         key_req,
    output logic [3:0]   key_round,
    input  logic         key_valid,
    input  logic [127:0] round_key,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [127:0] ciphertext
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_KEY     = 2'd1;
    localparam logic [1:0]  S_DONE    = 2'd2;
    localparam logic [3:0]  LAST_RND  = 4'(NR);
    localparam logic [15:0] WAIT_LAST = 16'(KEY_TIMEOUT - 1);

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box computed as x^254 (GF inverse, 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, b;
        sq = a;
        b  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            b  = gf_mul(b, sq);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Byte i sits at row i%4, column i/4; byte 0 is the MSB.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [127:0] st_q, st_d;
    logic [127:0] ct_q, ct_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [15:0]  wcnt_q, wcnt_d;
    logic         err_q, err_d;
    logic [127:0] sb_sr;
    logic [127:0] full_rnd;

    assign sb_sr    = sub_shift(st_q);
    assign full_rnd = mix_cols(sb_sr) ^ round_key;

    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        ct_d   = ct_q;
        rnd_d  = rnd_q;
        wcnt_d = wcnt_q;
        err_d  = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    st_d   = plaintext;
                    rnd_d  = 4'd0;
                    wcnt_d = 16'd0;
                    fsm_d  = S_KEY;
                end
            end
            S_KEY: begin
                if (key_valid) begin
                    wcnt_d = 16'd0;
                    if (rnd_q == 4'd0) begin
                        st_d = st_q ^ round_key;
                    end else if (rnd_q == LAST_RND) begin
                        ct_d  = sb_sr ^ round_key;
                        fsm_d = S_DONE;
                    end else begin
                        st_d = full_rnd;
                    end
                    if (rnd_q != LAST_RND) rnd_d = rnd_q + 4'd1;
                end else if (KEY_TIMEOUT != 0 && wcnt_q == WAIT_LAST) begin
                    // Abandon the block; ciphertext keeps the last good result.
                    err_d  = 1'b1;
                    st_d   = '0;
                    rnd_d  = 4'd0;
                    wcnt_d = 16'd0;
                    fsm_d  = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            S_DONE: begin
                rnd_d = 4'd0;
                fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= S_IDLE;
            st_q   <= '0;
            ct_q   <= '0;
            rnd_q  <= 4'd0;
            wcnt_q <= 16'd0;
            err_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            ct_q   <= ct_d;
            rnd_q  <= rnd_d;
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end

    assign key_req    = (fsm_q == S_KEY);
    assign busy       = (fsm_q == S_KEY);
    assign done       = (fsm_q == S_DONE);
    assign key_round  = rnd_q;
    assign error      = err_q;
    assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Bench for aes128_round_ctrl: FIPS-197 vectors with a local key-schedule model
// serving round keys, plus timeout, glitch and mid-round reset sequences.
module tb_aes128_round_ctrl;

    localparam int KT = 64;

    logic         clk, rst_n, start, key_req, key_valid, busy, done, error;
    logic [3:0]   key_round;
    logic [127:0] plaintext, round_key, ciphertext;

    aes128_round_ctrl #(.NR(10), .KEY_TIMEOUT(KT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .plaintext(plaintext),
        .key_req(key_req), .key_round(key_round), .key_valid(key_valid),
        .round_key(round_key), .busy(busy), .done(done), .error(error),
        .ciphertext(ciphertext)
    );

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t         vt [3];
    logic [127:0] rk [16];
    logic [127:0] sb_q [$];
    int           n_checks, n_err;
    int           kv_mode, withhold, exp_round;
    logic         kv_gen, kv_force;

    assign round_key = rk[key_round];
    assign key_valid = kv_gen | kv_force;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] tb_xtime(input logic [7:0] x);
        return x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, bb;
        p  = 8'h00;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) p = p ^ bb;
            bb = tb_xtime(bb);
        end
        return p;
    endfunction

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] inv, r, c;
        inv = 8'h00;
        c   = 8'h63;
        for (int y = 1; y < 256; y++)
            if (tb_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            r[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
        return r;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0]), tb_sbox(t[31:24])} ^ {rc, 24'h0};
                rc = tb_xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Key server: mode 0 answers immediately, mode 1 after 0..5 random cycles per round.
    initial begin
        int last_rnd, dly, dcnt;
        kv_gen   = 1'b0;
        last_rnd = -1;
        dly      = 0;
        dcnt     = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!key_req) begin
                kv_gen   = 1'b0;
                last_rnd = -1;
            end else if (int'(key_round) == withhold) begin
                kv_gen = 1'b0;
            end else if (kv_mode == 0) begin
                kv_gen = 1'b1;
            end else begin
                if (int'(key_round) != last_rnd) begin
                    last_rnd = int'(key_round);
                    dly      = $urandom_range(0, 5);
                    dcnt     = 0;
                end
                kv_gen = (dcnt >= dly);
                dcnt++;
            end
        end
    end

    // Monitor: key_round must follow accepts exactly; each done pops the scoreboard.
    initial begin
        exp_round = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!busy && !done) exp_round = 0;
                if (key_req) begin
                    check("key_round", 128'(key_round), 128'(exp_round));
                    if (key_valid) exp_round++;
                end
                if (done) begin
                    check("done_expected", 128'(sb_q.size() != 0), 128'(1));
                    if (sb_q.size() != 0) check("ciphertext", ciphertext, sb_q.pop_front());
                end
            end
        end
    end

    task automatic run_txn(input vec_t v, input int mode, input int hold, input int glitch,
                           input bit exp_err, input int exp_lat);
        logic [127:0] prev_ct;
        int           cyc;
        bit           gap, fin;
        expand(v.key);
        kv_mode  = mode;
        withhold = hold;
        @(negedge clk);
        prev_ct   = ciphertext;
        plaintext = v.pt;
        start     = 1'b1;
        if (!exp_err) sb_q.push_back(v.ct);
        @(negedge clk);
        start     = 1'b0;
        plaintext = '0;
        cyc = 1;
        gap = 1'b0;
        fin = 1'b0;
        // cyc counts clock periods after the start-accepting edge
        while (!fin && cyc < 2000) begin
            if (done || error) begin
                fin = 1'b1;
            end else begin
                if (!busy) gap = 1'b1;
                start     = (cyc == glitch);
                plaintext = (cyc == glitch) ? ~v.pt : '0;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check("txn_completed", 128'(fin), 128'(1));
        check("busy_continuous", 128'(gap), 128'(0));
        check("busy_at_end", 128'(busy), 128'(0));
        if (exp_err) begin
            check("error_pulse", 128'(error), 128'(1));
            check("done_on_error", 128'(done), 128'(0));
            check("ct_held", ciphertext, prev_ct);
        end else begin
            check("done_pulse", 128'(done), 128'(1));
            check("accept_count", 128'(exp_round), 128'(11));
        end
        if (exp_lat > 0) check("latency", 128'(cyc), 128'(exp_lat));
        if (!fin) sb_q.delete();
        @(negedge clk);
        check("done_one_cycle", 128'(done), 128'(0));
        check("error_one_cycle", 128'(error), 128'(0));
    endtask

    initial begin
        logic [127:0] prev_ct;
        bit           hit;
        n_checks  = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        plaintext = '0;
        kv_force  = 1'b0;
        kv_mode   = 0;
        withhold  = -1;
        for (int i = 0; i < 16; i++) rk[i] = '0;

        vt[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32};
        vt[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vt[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        repeat (3) @(negedge clk);
        check("rst_key_req", 128'(key_req), 128'(0));
        check("rst_key_round", 128'(key_round), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_error", 128'(error), 128'(0));
        check("rst_ciphertext", ciphertext, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) run_txn(vt[i], 0, -1, -1, 1'b0, 12);

        run_txn(vt[0], 1, -1, -1, 1'b0, 0);

        // Key withheld at round 4: rounds 0..3 take 4 periods, then KT waiting periods.
        run_txn(vt[1], 0, 4, -1, 1'b1, 5 + KT);
        run_txn(vt[1], 0, -1, -1, 1'b0, 12);

        prev_ct = ciphertext;
        @(negedge clk);
        kv_force = 1'b1;
        @(negedge clk);
        kv_force = 1'b0;
        @(negedge clk);
        check("idle_kv_busy", 128'(busy), 128'(0));
        check("idle_kv_key_req", 128'(key_req), 128'(0));
        check("idle_kv_ct", ciphertext, prev_ct);

        run_txn(vt[2], 0, -1, 5, 1'b0, 12);

        expand(vt[0].key);
        kv_mode  = 0;
        withhold = -1;
        @(negedge clk);
        plaintext = vt[0].pt;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        hit       = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (key_round == 4'd6) hit = 1'b1;
            else @(negedge clk);
        end
        check("reached_round6", 128'(hit), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_key_req", 128'(key_req), 128'(0));
        check("midrst_key_round", 128'(key_round), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        check("midrst_error", 128'(error), 128'(0));
        check("midrst_ciphertext", ciphertext, 128'(0));
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_txn(vt[0], 0, -1, -1, 1'b0, 12);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 128'(sb_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
